// File: rtl/result_unloader.sv
`timescale 1ns/1ps
// result_unloader: snapshots the multiplier's DIM x DIM result matrix when
// `finished` is seen in IDLE, streams it out BEAT elements per valid/ready
// transfer in row-major order, then parks in DONE until `finished` drops.
module result_unloader #(
  parameter int DIM   = 16,
  parameter int WIDTH = 4,
  parameter int BEAT  = 1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  finished,
  input  logic [DIM-1:0][DIM-1:0][2*WIDTH-1:0]  mat_in,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [BEAT*2*WIDTH-1:0]               m_data,
  output logic [$clog2(DIM)-1:0]                m_row,
  output logic [$clog2(DIM)-1:0]                m_col,
  output logic                                  m_last,
  output logic                                  busy,
  output logic                                  done
);

  localparam int EW   = 2 * WIDTH;          // element width
  localparam int NEL  = DIM * DIM;          // elements per matrix
  localparam int EIW  = $clog2(NEL);        // element index width
  localparam int IDXW = EIW + 1;            // idx can reach NEL without wrapping
  localparam int RW   = $clog2(DIM);        // row / column width

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NEL - BEAT);
  localparam logic [IDXW-1:0] BEAT_INC = IDXW'(BEAT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [NEL-1:0][EW-1:0] r_snap;   // element e lives at r_snap[e], row-major
  logic [IDXW-1:0]        r_idx;    // first element of the current beat
  logic [EIW-1:0]         w_elem;
  logic                   w_stream;
  logic                   w_last;
  logic                   w_xfer;

  assign w_elem   = r_idx[EIW-1:0];
  assign w_stream = (r_state == S_STREAM);
  assign w_last   = w_stream && (r_idx == LAST_IDX);
  assign w_xfer   = w_stream && m_ready;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic: capture on finished, leave STREAM on the last transfer,
  // rearm only after finished has been seen low.
  always_comb begin
    // NOTE: default first so no path through the case leaves w_next unassigned
    // (which would infer a latch).
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (finished)        w_next = S_STREAM;
      S_STREAM: if (w_xfer && w_last) w_next = S_DONE;
      S_DONE:   if (!finished)       w_next = S_IDLE;
      default:                       w_next = S_IDLE;
    endcase
  end

  // Snapshot capture and beat index advance.
  // NOTE: the snapshot is plain flops (not a RAM), so it is reset to zero
  // along with the index; it never feeds the outputs outside STREAM anyway.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap <= '0;
      r_idx  <= '0;
    end else if ((r_state == S_IDLE) && finished) begin
      r_snap <= mat_in;
      r_idx  <= '0;
    end else if (w_xfer) begin
      r_idx  <= r_idx + BEAT_INC;
    end
  end

  // Output decode: everything is a function of registered state only, so
  // m_ready never reaches m_valid combinationally. Outputs are zero off-stream.
  always_comb begin
    m_data  = '0;
    m_row   = '0;
    m_col   = '0;
    m_last  = 1'b0;
    m_valid = w_stream;
    busy    = w_stream;
    done    = (r_state == S_DONE);
    if (w_stream) begin
      for (int b = 0; b < BEAT; b++) begin
        m_data[b*EW +: EW] = r_snap[w_elem + EIW'(b)];
      end
      m_row  = w_elem[EIW-1 -: RW];
      m_col  = w_elem[RW-1:0];
      m_last = w_last;
    end
  end

endmodule
